// File: rtl/if_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage_if
// Purpose  : SRAM-like instruction-memory channel between the fetch stage
//            (master) and the instruction memory (slave). Reads only.
// Signals  : inst_sram_req/wr/size/wstrb/addr/wdata  master -> slave
//            inst_sram_addr_ok/data_ok/rdata          slave  -> master
// Revision : 1.0 - initial release
// ============================================================================
interface if_fetch_stage_if;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
    );

    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb,
               inst_sram_addr, inst_sram_wdata,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Purpose  : Instruction-fetch stage of the 5-stage LoongArch pipeline.
//            Generates the fetch PC, runs one outstanding request at a time
//            on the instruction SRAM channel, buffers returned words and
//            hands {ebus, inst, pc} to ID under valid/allow_in handshake.
//            Branch (BR_BUS) and flush redirects discard wrong-path fetches.
// Ports    : clk, resetn (async, active low)
//            inst_sram    - SRAM channel (master modport)
//            BR_BUS[32:0] - {br_target, br_taken} from ID
//            flush, flush_target - redirect from WB (wins over branch)
//            ID_allow_in  - ID accepts this cycle
//            IF_ready_go, IFreg_valid, IFreg_bus[79:0] = {ebus, inst, pc}
// Options  : IF_ADEF_EN - misaligned fetch PC raises ADEF instead of a fetch
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h1C00_0000,
    parameter int          EBUS_ADEF = 1
) (
    input  wire logic            clk,
    input  wire logic            resetn,
    if_fetch_stage_if.master     inst_sram,
    input  wire logic [32:0]     BR_BUS,
    input  wire logic            flush,
    input  wire logic [31:0]     flush_target,
    input  wire logic            ID_allow_in,
    output logic                 IF_ready_go,
    output logic                 IFreg_valid,
    output logic [79:0]          IFreg_bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_pc;
    logic [31:0] r_if_pc;
    logic [31:0] r_buf_inst;
    logic        r_if_valid;
    logic        r_buf_valid;
    logic        r_discard;
    logic        r_redirect_pending;

    logic        w_br_taken;
    logic [31:0] w_br_target;
    logic        w_cancel;
    logic [31:0] w_new_pc;
    logic        w_accept;
    logic        w_data_take;
    logic        w_slot_free;
    logic        w_fetch_ok;
    logic        w_start_req;
    logic        w_leave;
    logic        w_adef;
    logic [31:0] w_inst;
    logic [15:0] w_ebus;

    assign w_br_taken  = BR_BUS[0];
    assign w_br_target = BR_BUS[32:1];
    assign w_cancel    = flush | w_br_taken;
    assign w_new_pc    = flush ? flush_target : w_br_target;

    assign w_accept    = (r_state == S_REQ) & inst_sram.inst_sram_addr_ok;
    assign w_data_take = (r_state == S_WAIT) & inst_sram.inst_sram_data_ok & ~r_discard;

    assign IF_ready_go = r_if_valid & (r_buf_valid | w_data_take | w_adef);
    assign IFreg_valid = IF_ready_go & ~w_cancel;
    assign w_leave     = IFreg_valid & ID_allow_in;

    // The slot is free if empty, or if its current occupant leaves this cycle.
    assign w_slot_free = ~r_if_valid | (IF_ready_go & ID_allow_in);
    assign w_fetch_ok  = (r_state == S_IDLE) & ~w_cancel & w_slot_free;

`ifdef IF_ADEF_EN
    logic r_adef;
    logic r_adef_stall;
    logic w_misaligned;
    logic w_start_adef;

    assign w_misaligned = (r_fetch_pc[1:0] != 2'b00);
    assign w_start_req  = w_fetch_ok & ~w_misaligned;
    // Stall flag prevents the fault from being raised again after ID takes it.
    assign w_start_adef = w_fetch_ok & w_misaligned & ~r_adef_stall;
    assign w_adef       = r_adef;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_adef       <= 1'b0;
            r_adef_stall <= 1'b0;
        end else begin
            if (w_cancel || w_leave)
                r_adef <= 1'b0;
            else if (w_start_adef)
                r_adef <= 1'b1;
            // A cancel of a still-pending fault means it was wrong-path.
            if (flush || (w_cancel && r_adef))
                r_adef_stall <= 1'b0;
            else if (w_start_adef)
                r_adef_stall <= 1'b1;
        end
    end
`else
    assign w_start_req = w_fetch_ok;
    assign w_adef      = 1'b0;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_req) w_state_nxt = S_REQ;
            S_REQ:   if (inst_sram.inst_sram_addr_ok) w_state_nxt = S_WAIT;
            S_WAIT:  if (inst_sram.inst_sram_data_ok) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fetch_pc         <= RESET_PC;
            r_req_pc           <= RESET_PC;
            r_if_pc            <= 32'h0;
            r_buf_inst         <= 32'h0;
            r_if_valid         <= 1'b0;
            r_buf_valid        <= 1'b0;
            r_discard          <= 1'b0;
            r_redirect_pending <= 1'b0;
        end else begin
            // While redirect_pending, fetch_pc already holds the redirect
            // target and must not be advanced by the wrong-path accept.
            if (w_cancel)
                r_fetch_pc <= w_new_pc;
            else if (w_accept && !r_redirect_pending)
                r_fetch_pc <= r_req_pc + 32'd4;

            // The request in S_REQ cannot be withdrawn; remember the redirect.
            if ((r_state == S_REQ) && w_cancel)
                r_redirect_pending <= 1'b1;
            else if ((r_state == S_WAIT) && inst_sram.inst_sram_data_ok)
                r_redirect_pending <= 1'b0;

            if (w_start_req)
                r_req_pc <= r_fetch_pc;

            if (w_accept && (w_cancel || r_redirect_pending))
                r_discard <= 1'b1;
            else if ((r_state == S_WAIT) && inst_sram.inst_sram_data_ok)
                r_discard <= 1'b0;
            else if ((r_state == S_WAIT) && w_cancel)
                r_discard <= 1'b1;

            // A new accept in the same cycle as a leave keeps the slot full.
            if (w_cancel && (r_state != S_REQ))
                r_if_valid <= 1'b0;
            else if (w_accept && !w_cancel && !r_redirect_pending) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= r_req_pc;
            end else if (w_leave)
                r_if_valid <= 1'b0;
`ifdef IF_ADEF_EN
            else if (w_start_adef) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= r_fetch_pc;
            end
`endif

            if (w_cancel)
                r_buf_valid <= 1'b0;
            else if (w_data_take && !ID_allow_in) begin
                r_buf_valid <= 1'b1;
                r_buf_inst  <= inst_sram.inst_sram_rdata;
            end else if (w_leave)
                r_buf_valid <= 1'b0;
        end
    end

    // ---------------- outputs ----------------
    assign inst_sram.inst_sram_req   = (r_state == S_REQ);
    assign inst_sram.inst_sram_addr  = {r_req_pc[31:2], 2'b00};
    assign inst_sram.inst_sram_wr    = 1'b0;
    assign inst_sram.inst_sram_size  = 2'b10;
    assign inst_sram.inst_sram_wstrb = 4'h0;
    assign inst_sram.inst_sram_wdata = 32'h0;

    always_comb begin
        w_ebus            = 16'h0;
        w_ebus[EBUS_ADEF] = w_adef;
    end

    assign w_inst = w_adef      ? 32'h0 :
                    r_buf_valid ? r_buf_inst : inst_sram.inst_sram_rdata;

    // Bus is zeroed while empty so nothing stale or undriven reaches ID.
    assign IFreg_bus = r_if_valid ? {w_ebus, w_inst, r_if_pc} : 80'h0;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_stage
// Purpose  : Self-checking bench for if_fetch_stage. A bench-side SRAM model
//            accepts a controlled number of requests; expected {ebus,inst,pc}
//            words are queued as stimulus is issued and popped on delivery.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic [32:0] br_bus;
    logic        flush;
    logic [31:0] flush_target;
    logic        id_allow_in;
    logic        if_ready_go;
    logic        ifreg_valid;
    logic [79:0] ifreg_bus;

    if_fetch_stage_if u_sram_if ();

    if_fetch_stage dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_sram    (u_sram_if),
        .BR_BUS       (br_bus),
        .flush        (flush),
        .flush_target (flush_target),
        .ID_allow_in  (id_allow_in),
        .IF_ready_go  (if_ready_go),
        .IFreg_valid  (ifreg_valid),
        .IFreg_bus    (ifreg_bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          budget   = 0;
    int          resp_lat = 1;
    int          acc_cnt  = 0;
    logic [79:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h1C00_0010) return 32'h0280_0421;
        return a ^ 32'hA5A5_0F0F;
    endfunction

    function automatic logic [79:0] pack(input logic [15:0] e, input logic [31:0] i, input logic [31:0] p);
        return {e, i, p};
    endfunction

    // SRAM model: drives at negedge+1, accepts only while budget > 0.
    initial begin
        int          resp_cnt;
        logic [31:0] resp_addr;
        logic [31:0] held_addr;
        bit          held;
        resp_cnt  = 0;
        resp_addr = '0;
        held_addr = '0;
        held      = 0;
        u_sram_if.inst_sram_addr_ok = 1'b0;
        u_sram_if.inst_sram_data_ok = 1'b0;
        u_sram_if.inst_sram_rdata   = '0;
        forever begin
            @(negedge clk);
            #1;
            u_sram_if.inst_sram_addr_ok = 1'b0;
            u_sram_if.inst_sram_data_ok = 1'b0;
            u_sram_if.inst_sram_rdata   = $urandom;
            if (!resetn) begin
                resp_cnt = 0;
                held     = 0;
            end else begin
                if (resp_cnt != 0) begin
                    resp_cnt--;
                    if (resp_cnt == 0) begin
                        u_sram_if.inst_sram_data_ok = 1'b1;
                        u_sram_if.inst_sram_rdata   = mem_word(resp_addr);
                    end
                end
                if (u_sram_if.inst_sram_req) begin
                    if (held) check_eq("addr_stable", u_sram_if.inst_sram_addr, held_addr);
                    if (budget > 0) begin
                        budget--;
                        acc_cnt++;
                        u_sram_if.inst_sram_addr_ok = 1'b1;
                        resp_cnt  = resp_lat;
                        resp_addr = u_sram_if.inst_sram_addr;
                        held      = 0;
                    end else begin
                        held      = 1;
                        held_addr = u_sram_if.inst_sram_addr;
                    end
                end else begin
                    held = 0;
                end
            end
        end
    end

    // Delivery monitor, sampled one time unit before the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (resetn) begin
                if (br_bus[0] || flush) check_eq("valid_under_cancel", ifreg_valid, 1'b0);
                if (ifreg_valid && id_allow_in) begin
                    if (exp_q.size() == 0) check_eq("unexpected_delivery", 1'b1, 1'b0);
                    else check_eq("deliver", ifreg_bus, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic accept_one(input string tag);
        int start;
        start  = acc_cnt;
        budget = 1;
        for (int i = 0; i < 60 && acc_cnt == start; i++) @(negedge clk);
        check_eq({"accept_", tag}, 80'(acc_cnt != start), 80'd1);
    endtask

    task automatic wait_req(input string tag, input logic [31:0] a);
        bit seen;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            #3;
            seen = u_sram_if.inst_sram_req;
        end
        check_eq({"req_seen_", tag}, 80'(seen), 80'd1);
        check_eq({"req_addr_", tag}, u_sram_if.inst_sram_addr, a);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check_eq({"drain_", tag}, 80'(exp_q.size()), 80'd0);
    endtask

    task automatic pulse_cancel(input logic br, input logic [31:0] tgt, input logic fl, input logic [31:0] ftgt);
        @(negedge clk);
        br_bus       = {tgt, br};
        flush        = fl;
        flush_target = ftgt;
        @(negedge clk);
        br_bus       = '0;
        flush        = 1'b0;
    endtask

    initial begin
        resetn       = 1'b0;
        br_bus       = '0;
        flush        = 1'b0;
        flush_target = '0;
        id_allow_in  = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        check_eq("rst_req",    u_sram_if.inst_sram_req, 1'b0);
        check_eq("rst_valid",  ifreg_valid, 1'b0);
        check_eq("rst_ready",  if_ready_go, 1'b0);
        check_eq("rst_bus",    ifreg_bus, 80'h0);
        check_eq("tie_wr",     u_sram_if.inst_sram_wr, 1'b0);
        check_eq("tie_size",   u_sram_if.inst_sram_size, 2'b10);
        check_eq("tie_wstrb",  u_sram_if.inst_sram_wstrb, 4'h0);
        check_eq("tie_wdata",  u_sram_if.inst_sram_wdata, 32'h0);

        // Streaming: four fetches delivered in order.
        budget   = 4;
        resp_lat = 1;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] p;
            p = 32'h1C00_0000 + 32'(4 * k);
            exp_q.push_back(pack(16'h0, mem_word(p), p));
        end
        @(negedge clk);
        resetn = 1'b1;
        #3;
        check_eq("req_cycle0", u_sram_if.inst_sram_req, 1'b0);
        @(negedge clk);
        #3;
        check_eq("req_cycle1", u_sram_if.inst_sram_req, 1'b1);
        check_eq("addr_cycle1", u_sram_if.inst_sram_addr, 32'h1C00_0000);
        wait_drain("stream");

        // Buffering while ID is stalled.
        wait_req("buf", 32'h1C00_0010);
        id_allow_in = 1'b0;
        exp_q.push_back(pack(16'h0, 32'h0280_0421, 32'h1C00_0010));
        accept_one("buf");
        for (int i = 0; i < 10 && !if_ready_go; i++) begin
            @(negedge clk);
            #3;
        end
        check_eq("buf_ready", if_ready_go, 1'b1);
        check_eq("buf_valid", ifreg_valid, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #3;
            check_eq("buf_no_req", u_sram_if.inst_sram_req, 1'b0);
            check_eq("buf_inst",   ifreg_bus[63:32], 32'h0280_0421);
        end
        @(negedge clk);
        id_allow_in = 1'b1;
        wait_req("after_buf", 32'h1C00_0014);
        check_eq("buf_drained", 80'(exp_q.size()), 80'd0);

        // Branch while waiting for data: response must be dropped.
        resp_lat = 2;
        accept_one("wait_br");
        br_bus = {32'h1C00_0100, 1'b1};
        @(negedge clk);
        br_bus   = '0;
        resp_lat = 1;
        wait_req("wait_br", 32'h1C00_0100);
        exp_q.push_back(pack(16'h0, mem_word(32'h1C00_0100), 32'h1C00_0100));
        accept_one("wait_br_next");
        wait_drain("wait_br");

        // Branch while the request is held without addr_ok.
        wait_req("req_br_hold", 32'h1C00_0104);
        pulse_cancel(1'b1, 32'h1C00_0100, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        #3;
        check_eq("req_br_held_addr", u_sram_if.inst_sram_addr, 32'h1C00_0104);
        accept_one("req_br_stale");
        wait_req("req_br", 32'h1C00_0100);
        exp_q.push_back(pack(16'h0, mem_word(32'h1C00_0100), 32'h1C00_0100));
        accept_one("req_br_next");
        wait_drain("req_br");

        // Flush and branch in the same cycle: flush wins.
        wait_req("flush_hold", 32'h1C00_0104);
        pulse_cancel(1'b1, 32'h1C00_0300, 1'b1, 32'h1C00_8000);
        accept_one("flush_stale");
        wait_req("flush", 32'h1C00_8000);
        exp_q.push_back(pack(16'h0, mem_word(32'h1C00_8000), 32'h1C00_8000));
        accept_one("flush_next");
        wait_drain("flush");

        // Misaligned branch target.
        wait_req("mis_hold", 32'h1C00_8004);
        pulse_cancel(1'b1, 32'h1C00_0102, 1'b0, 32'h0);
        accept_one("mis_stale");
`ifdef IF_ADEF_EN
        exp_q.push_back(pack(16'h0002, 32'h0, 32'h1C00_0102));
        wait_drain("adef");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #3;
            check_eq("adef_no_req", u_sram_if.inst_sram_req, 1'b0);
        end
`else
        wait_req("mis", 32'h1C00_0100);
        exp_q.push_back(pack(16'h0, mem_word(32'h1C00_0100), 32'h1C00_0102));
        accept_one("mis_next");
        wait_drain("mis");
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
